// File: rtl/float_to_int_if.sv
// Handshake bundle between a float producer and the float_to_int converter.
// The converter connects through the slave modport; the producer and consumer use master.
interface float_to_int_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/float_to_int.sv
// IEEE-754 single-precision to signed 32-bit integer, truncating toward zero.
// Out-of-range magnitudes, infinities and NaNs produce 0x80000000.
module float_to_int (
  input logic           clk,
  input logic           rst,
  float_to_int_if.slave bus
);

  localparam logic [2:0] GET_A         = 3'd0;
  localparam logic [2:0] UNPACK        = 3'd1;
  localparam logic [2:0] SPECIAL_CASES = 3'd2;
  localparam logic [2:0] CONVERT       = 3'd3;
  localparam logic [2:0] PUT_Z         = 3'd4;

  localparam logic [31:0] INDEFINITE = 32'h8000_0000;

  logic [2:0]        state;
  logic [31:0]       a;
  logic [31:0]       m;
  logic signed [9:0] e;
  logic              s;
  logic [31:0]       z;
  logic              special;

  // Two's-complement negation wraps modulo 2^32.
  function automatic logic [31:0] apply_sign(input logic sgn, input logic [31:0] mag);
    return sgn ? (~mag + 32'd1) : mag;
  endfunction

  // Infinity/NaN (e == 128) is covered by e > 30; zero and |a| < 1 by e < 0.
  always_comb begin
    special = (e > 10'sd30) || (e < 10'sd0);
  end

  // Datapath registers: no reset, only meaningful once the FSM has loaded them.
  always_ff @(posedge clk) begin
    case (state)
      GET_A: begin
        if (bus.input_a_ack && bus.input_a_stb) begin
          a <= bus.input_a;
        end
      end
      UNPACK: begin
        m <= {1'b1, a[22:0], 8'd0};
        e <= $signed({2'b00, a[30:23]}) - 10'sd127;
        s <= a[31];
      end
      SPECIAL_CASES: begin
        if (e == 10'sd128) begin
          z <= INDEFINITE;
        end else if (e > 10'sd30) begin
          z <= INDEFINITE;
        end else if (e < 10'sd0) begin
          z <= 32'd0;
        end
      end
      CONVERT: begin
        // One bit of right shift per cycle; shifted-out bits are the truncated fraction.
        if (e < 10'sd31) begin
          m <= m >> 1;
          e <= e + 10'sd1;
        end else begin
          z <= apply_sign(s, m);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= GET_A;
      bus.input_a_ack  <= 1'b0;
      bus.output_z_stb <= 1'b0;
      bus.output_z     <= 32'd0;
    end else begin
      case (state)
        GET_A: begin
          bus.input_a_ack <= 1'b1;
          if (bus.input_a_ack && bus.input_a_stb) begin
            bus.input_a_ack <= 1'b0;
            state           <= UNPACK;
          end
        end
        UNPACK: begin
          state <= SPECIAL_CASES;
        end
        SPECIAL_CASES: begin
          state <= special ? PUT_Z : CONVERT;
        end
        CONVERT: begin
          if (!(e < 10'sd31)) begin
            state <= PUT_Z;
          end
        end
        PUT_Z: begin
          bus.output_z_stb <= 1'b1;
          bus.output_z     <= z;
          if (bus.output_z_stb && bus.output_z_ack) begin
            bus.output_z_stb <= 1'b0;
            state            <= GET_A;
          end
        end
        default: begin
          state <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Directed and randomized checks of the float_to_int converter: reset, latency,
// truncation, saturation, backpressure, mid-conversion reset and streaming order.
module tb_float_to_int;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_to_int_if bus();

  float_to_int dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Reference C (int) cast with saturation, written from the float format directly.
  function automatic logic [31:0] ref_int(input logic [31:0] f);
    int ex;
    logic [31:0] mag;
    ex = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF || ex > 30) return 32'h8000_0000;
    if (ex < 0) return 32'd0;
    mag = {8'd0, 1'b1, f[22:0]};
    if (ex >= 23) mag = mag << (ex - 23);
    else          mag = mag >> (23 - ex);
    return f[31] ? -mag : mag;
  endfunction

  // Presents an operand and returns just after the accepting edge.
  task automatic accept(input logic [31:0] val, output bit ok);
    @(negedge clk);
    bus.input_a     = val;
    bus.input_a_stb = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (bus.input_a_ack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    bus.input_a_stb = 1'b0;
  endtask

  // Counts edges until output_z_stb rises; -1 if it never does.
  task automatic wait_stb(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.output_z_stb) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_z();
    @(negedge clk);
    bus.output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.input_a_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.input_a_ack); end
    total++; if (bus.output_z_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", bus.output_z_stb); end
    total++; if (bus.output_z !== 32'd0) begin bad++; $display("FAIL reset_z: got %h want 00000000", bus.output_z); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.input_a_ack !== 1'b1) begin bad++; $display("FAIL ack_after_reset: got %b want 1", bus.input_a_ack); end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    accept(32'h3F80_0000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_accept: got %b want 1", ok); end
    total++; if (bus.input_a_ack !== 1'b0) begin bad++; $display("FAIL basic_ack_drop: got %b want 0", bus.input_a_ack); end
    wait_stb(lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL basic_latency: got %0d want 35", lat); end
    total++; if (bus.output_z !== 32'h0000_0001) begin bad++; $display("FAIL basic_z: got %h want 00000001", bus.output_z); end
    release_z();
    total++; if (bus.output_z_stb !== 1'b0) begin bad++; $display("FAIL basic_stb_drop: got %b want 0", bus.output_z_stb); end
  endtask

  task automatic test_vectors();
    logic [31:0] va[9] = '{32'hC049_0FDB, 32'h4EFF_FFFF, 32'h3F00_0000, 32'h8000_0000,
                           32'h4F00_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'hCF00_0000,
                           32'h4120_0000};
    logic [31:0] vz[9] = '{32'hFFFF_FFFD, 32'h7FFF_FF80, 32'h0000_0000, 32'h0000_0000,
                           32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                           32'h0000_000A};
    int vl[9] = '{34, 5, 3, 3, 3, 3, 3, 3, 32};
    bit ok;
    int lat;
    for (int i = 0; i < 9; i++) begin
      accept(va[i], ok);
      wait_stb(lat);
      total++; if (lat !== vl[i]) begin bad++; $display("FAIL vec%0d_latency (%h): got %0d want %0d", i, va[i], lat, vl[i]); end
      total++; if (bus.output_z !== vz[i]) begin bad++; $display("FAIL vec%0d_z (%h): got %h want %h", i, va[i], bus.output_z, vz[i]); end
      release_z();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int held_bad = 0;
    accept(32'h3F80_0000, ok);
    wait_stb(lat);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.output_z_stb !== 1'b1 || bus.output_z !== 32'h0000_0001) held_bad++;
    end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", held_bad); end
    release_z();
    total++; if (bus.output_z_stb !== 1'b0) begin bad++; $display("FAIL hold_stb_drop: got %b want 0", bus.output_z_stb); end
    total++; if (bus.input_a_ack !== 1'b0) begin bad++; $display("FAIL hold_ack_early: got %b want 0", bus.input_a_ack); end
    @(posedge clk);
    #1;
    total++; if (bus.input_a_ack !== 1'b1) begin bad++; $display("FAIL hold_ack_return: got %b want 1", bus.input_a_ack); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    int lat;
    accept(32'h3F80_0000, ok);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.output_z_stb) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_pulse: got %b want 0", seen); end
    accept(32'h4120_0000, ok);
    wait_stb(lat);
    total++; if (bus.output_z !== 32'h0000_000A) begin bad++; $display("FAIL midreset_next_z: got %h want 0000000a", bus.output_z); end
    total++; if (lat !== 32) begin bad++; $display("FAIL midreset_next_latency: got %0d want 32", lat); end
    release_z();
  endtask

  task automatic test_back_to_back();
    int got = 0;
    exp_q.delete();
    fork
      begin : driver
        bit ok;
        logic [31:0] f;
        int r;
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          r = $urandom_range(0, 9);
          f[31]    = $urandom_range(0, 1);
          f[22:0]  = $urandom;
          if (r == 0)      f[30:23] = 8'hFF;
          else if (r == 1) f[30:23] = 8'h00;
          else             f[30:23] = 8'($urandom_range(110, 165));
          accept(f, ok);
          if (!ok) begin
            total++; bad++;
            $display("FAIL stream_accept_timeout: operand %0d not taken", i);
            break;
          end
          exp_q.push_back(ref_int(f));
        end
      end
      begin : monitor
        bit ack_now;
        logic [31:0] want;
        for (int c = 0; c < 30000 && got < 200; c++) begin
          @(negedge clk);
          ack_now = ($urandom_range(0, 2) != 0);
          bus.output_z_ack = ack_now;
          if (bus.output_z_stb && ack_now) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL stream_extra: got %h want no output", bus.output_z);
            end else begin
              want = exp_q.pop_front();
              if (bus.output_z !== want) begin
                bad++;
                $display("FAIL stream_z%0d: got %h want %h", got, bus.output_z, want);
              end
            end
          end
        end
        @(negedge clk);
        bus.output_z_ack = 1'b0;
      end
    join
    total++; if (got !== 200) begin bad++; $display("FAIL stream_count: got %0d want 200", got); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stream_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    bus.input_a      = 32'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
